// File: rtl/lcd_string_writer.sv
// Writes a latched 32-character ASCII string to a 2x16 HD44780 LCD over an 8-bit bus.
// Runs the LCD init sequence once after reset; all timing comes from cycle-count parameters.
module lcd_string_writer #(
    parameter int unsigned POWERUP_CYCLES = 750000,
    parameter int unsigned E_PULSE_CYCLES = 25,
    parameter int unsigned CMD_CYCLES     = 2500,
    parameter int unsigned CLEAR_CYCLES   = 100000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [255:0] ascii_string,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic         lcd_rs,
    output logic         lcd_rw,
    output logic         lcd_e,
    output logic [7:0]   lcd_data
);

    localparam int unsigned MAX_A   = (POWERUP_CYCLES > E_PULSE_CYCLES) ? POWERUP_CYCLES : E_PULSE_CYCLES;
    localparam int unsigned MAX_B   = (CMD_CYCLES > CLEAR_CYCLES) ? CMD_CYCLES : CLEAR_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CW      = $clog2(MAX_CYC + 1);
    localparam int unsigned IW      = 6;
    localparam logic [IW-1:0] INIT_LAST = IW'(3);
    localparam logic [IW-1:0] STR_LAST  = IW'(33);

    typedef enum logic [2:0] {
        S_PWRUP,
        S_SETUP,
        S_EHI,
        S_WAIT,
        S_IDLE
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            str_mode_q, str_mode_d;
    logic            pending_q, pending_d;
    logic [255:0]    str_q, str_d;
    logic            rs_q, rs_d;
    logic [7:0]      data_q, data_d;
    logic            busy_q, e_q, done_q, done_d;
    logic            load_byte;
    logic            last_byte;
    logic [CW-1:0]   wait_last;

    // {rs, data} for sequence position idx; NUL characters are shown as spaces
    function automatic logic [8:0] seq_byte(input logic str_mode, input logic [IW-1:0] idx,
                                            input logic [255:0] s);
        logic [7:0] ch;
        logic [4:0] k;
        seq_byte = 9'h000;
        ch       = 8'h00;
        k        = 5'd0;
        if (!str_mode) begin
            case (idx[1:0])
                2'd0:    seq_byte = 9'h038;
                2'd1:    seq_byte = 9'h00C;
                2'd2:    seq_byte = 9'h001;
                default: seq_byte = 9'h006;
            endcase
        end else if (idx == IW'(0)) begin
            seq_byte = 9'h080;
        end else if (idx == IW'(17)) begin
            seq_byte = 9'h0C0;
        end else begin
            k  = (idx < IW'(17)) ? 5'(idx - IW'(1)) : 5'(idx - IW'(2));
            ch = s[{~k, 3'b000} +: 8];
            seq_byte = {1'b1, (ch == 8'h00) ? 8'h20 : ch};
        end
    endfunction

    assign last_byte = str_mode_q ? (idx_q == STR_LAST) : (idx_q == INIT_LAST);
    assign wait_last = (!rs_q && data_q == 8'h01) ? CW'(CLEAR_CYCLES - 1) : CW'(CMD_CYCLES - 1);

    // Next-state logic for power-up, init list, string sequence and byte engine
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        str_mode_d = str_mode_q;
        pending_d  = pending_q;
        str_d      = str_q;
        rs_d       = rs_q;
        data_d     = data_q;
        done_d     = 1'b0;
        load_byte  = 1'b0;

        if (start && !str_mode_q && state_q != S_IDLE) begin
            pending_d = 1'b1;
        end

        case (state_q)
            S_PWRUP: begin
                if (cnt_q == CW'(POWERUP_CYCLES - 1)) begin
                    cnt_d      = '0;
                    idx_d      = '0;
                    str_mode_d = 1'b0;
                    state_d    = S_SETUP;
                    load_byte  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_SETUP: begin
                cnt_d   = '0;
                state_d = S_EHI;
            end
            S_EHI: begin
                if (cnt_q == CW'(E_PULSE_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAIT: begin
                if (cnt_q == wait_last) begin
                    cnt_d = '0;
                    if (!last_byte) begin
                        idx_d     = idx_q + IW'(1);
                        state_d   = S_SETUP;
                        load_byte = 1'b1;
                    end else if (str_mode_q) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else if (pending_q || start) begin
                        // Init finished with a queued request: go straight into the string
                        pending_d  = 1'b0;
                        str_d      = ascii_string;
                        str_mode_d = 1'b1;
                        idx_d      = '0;
                        state_d    = S_SETUP;
                        load_byte  = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_IDLE: begin
                if (start) begin
                    str_d      = ascii_string;
                    str_mode_d = 1'b1;
                    idx_d      = '0;
                    cnt_d      = '0;
                    state_d    = S_SETUP;
                    load_byte  = 1'b1;
                end
            end
            default: state_d = S_PWRUP;
        endcase

        if (load_byte) begin
            {rs_d, data_d} = seq_byte(str_mode_d, idx_d, str_d);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_PWRUP;
            cnt_q      <= '0;
            idx_q      <= '0;
            str_mode_q <= 1'b0;
            pending_q  <= 1'b0;
            str_q      <= '0;
            rs_q       <= 1'b0;
            data_q     <= 8'h00;
            busy_q     <= 1'b1;
            e_q        <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            str_mode_q <= str_mode_d;
            pending_q  <= pending_d;
            str_q      <= str_d;
            rs_q       <= rs_d;
            data_q     <= data_d;
            busy_q     <= (state_d != S_IDLE);
            e_q        <= (state_d == S_EHI);
            done_q     <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign lcd_rs   = rs_q;
    assign lcd_rw   = 1'b0;
    assign lcd_e    = e_q;
    assign lcd_data = data_q;

endmodule

// File: tb/tb_lcd_string_writer.sv
// Self-checking bench for lcd_string_writer: observed E-strobe bytes and timing are compared
// against a byte-list model built from the string and the LCD init rules.
module tb_lcd_string_writer;

    localparam int unsigned PU = 20;
    localparam int unsigned EP = 2;
    localparam int unsigned CM = 4;
    localparam int unsigned CL = 10;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [255:0] ascii_string;
    logic         start;
    logic         busy, done, lcd_rs, lcd_rw, lcd_e;
    logic [7:0]   lcd_data;

    lcd_string_writer #(
        .POWERUP_CYCLES(PU),
        .E_PULSE_CYCLES(EP),
        .CMD_CYCLES    (CM),
        .CLEAR_CYCLES  (CL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ascii_string(ascii_string),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .lcd_rs      (lcd_rs),
        .lcd_rw      (lcd_rw),
        .lcd_e       (lcd_e),
        .lcd_data    (lcd_data)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [8:0] seen_q[$];
    logic [8:0] exp_q[$];
    int         rise_cyc[$];
    int         fall_cyc[$];
    int         done_cnt = 0;
    int         done_cyc = 0;
    logic       busy_at_done = 1'b1;
    logic       prev_e = 1'b0;
    logic [8:0] held = 9'h000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bus monitor: records each strobe's byte and edges, checks strobe width and bus stability
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_e = 1'b0;
        end else begin
            if (lcd_rw !== 1'b0) chk("lcd_rw_low", 32'(lcd_rw), 32'd0);
            if (lcd_e && !prev_e) begin
                seen_q.push_back({lcd_rs, lcd_data});
                rise_cyc.push_back(cyc);
                held = {lcd_rs, lcd_data};
            end else if (lcd_e) begin
                chk("e_high_bus_stable", 32'({lcd_rs, lcd_data}), 32'(held));
            end else if (prev_e && rise_cyc.size() > 0) begin
                fall_cyc.push_back(cyc);
                chk("e_width", 32'(cyc - rise_cyc[$]), EP);
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc     = cyc;
                busy_at_done = busy;
            end
            prev_e = lcd_e;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mon();
        seen_q.delete();
        rise_cyc.delete();
        fall_cyc.delete();
        done_cnt = 0;
    endtask

    // Reference model: the byte list the LCD must receive
    task automatic build_exp(input logic [255:0] s, input bit with_init, input bit with_str);
        logic [7:0] c;
        exp_q.delete();
        if (with_init) begin
            exp_q.push_back(9'h038);
            exp_q.push_back(9'h00C);
            exp_q.push_back(9'h001);
            exp_q.push_back(9'h006);
        end
        if (with_str) begin
            for (int k = 0; k < 32; k++) begin
                if (k == 0)  exp_q.push_back(9'h080);
                if (k == 16) exp_q.push_back(9'h0C0);
                c = s[255 - 8*k -: 8];
                exp_q.push_back({1'b1, (c == 8'h00) ? 8'h20 : c});
            end
        end
    endtask

    task automatic compare_seq(input string tag);
        int n;
        chk({tag, "_count"}, 32'(seen_q.size()), 32'(exp_q.size()));
        n = (seen_q.size() < exp_q.size()) ? seen_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk(tag, 32'(seen_q[i]), 32'(exp_q[i]));
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        while (busy !== 1'b0 && k < budget) begin
            tick();
            k++;
        end
        chk(tag, 32'(k < budget), 32'd1);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (done_cnt == 0 && k < budget) begin
            tick();
            k++;
        end
        chk(tag, 32'(k < budget), 32'd1);
    endtask

    task automatic wait_rises(input string tag, input int n, input int budget);
        int k = 0;
        while (seen_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk(tag, 32'(k < budget), 32'd1);
    endtask

    function automatic logic [255:0] rand_string();
        logic [255:0] s;
        logic [7:0]   c;
        s = '0;
        for (int k = 0; k < 32; k++) begin
            c = 8'($urandom_range(0, 255));
            if (c == 8'h01 || $urandom_range(0, 7) == 0) c = 8'h00;
            s[255 - 8*k -: 8] = c;
        end
        return s;
    endfunction

    localparam int unsigned BYTE_STR = 1 + EP + CM;

    initial begin
        int           rel_cyc;
        int           st_cyc;
        int           drops;
        logic [255:0] s_a;
        logic [255:0] s_b;

        rst_n        = 1'b0;
        start        = 1'b0;
        ascii_string = '0;
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rs", 32'(lcd_rs), 32'd0);
        chk("rst_e", 32'(lcd_e), 32'd0);
        chk("rst_data", 32'(lcd_data), 32'h00);
        chk("rst_rw", 32'(lcd_rw), 32'd0);

        // Power-up and init sequence
        rst_n   = 1'b1;
        rel_cyc = cyc;
        wait_idle("init_idle_timeout", 400);
        chk("first_rise_delay", 32'(rise_cyc.size() > 0 ? rise_cyc[0] - rel_cyc : -1), PU + 1);
        build_exp('0, 1'b1, 1'b0);
        compare_seq("init_seq");
        chk("clear_gap", 32'(rise_cyc.size() > 3 ? rise_cyc[3] - fall_cyc[2] : -1), CL + 1);
        chk("init_no_done", 32'(done_cnt), 32'd0);

        // Directed string from idle
        clear_mon();
        s_a          = {"CAP=0x17 ID=0xEFTYPE=0x40", 56'h0};
        ascii_string = s_a;
        start        = 1'b1;
        st_cyc       = cyc + 1;
        tick();
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        wait_done("str_done_timeout", 600);
        chk("done_latency", 32'(done_cyc - st_cyc), 34 * BYTE_STR);
        chk("busy_low_at_done", 32'(busy_at_done), 32'd0);
        repeat (5) tick();
        chk("str_done_once", 32'(done_cnt), 32'd1);
        build_exp(s_a, 1'b0, 1'b1);
        compare_seq("str_seq");

        // Start during power-up: queued behind init with no idle gap
        rst_n = 1'b0;
        tick();
        clear_mon();
        rst_n = 1'b1;
        repeat (5) tick();
        s_a          = rand_string();
        ascii_string = s_a;
        start        = 1'b1;
        tick();
        start = 1'b0;
        drops = 0;
        for (int k = 0; k < 1000 && done_cnt == 0; k++) begin
            tick();
            if (busy !== 1'b1 && done_cnt == 0) drops++;
        end
        chk("pend_done_seen", 32'(done_cnt), 32'd1);
        chk("pend_busy_drops", 32'(drops), 32'd0);
        build_exp(s_a, 1'b1, 1'b1);
        compare_seq("pend_seq");
        chk("pend_gap", 32'(rise_cyc.size() > 4 ? rise_cyc[4] - fall_cyc[3] : -1), CM + 1);

        // Re-start and string change mid-write are ignored
        tick();
        clear_mon();
        s_a          = rand_string();
        s_b          = rand_string();
        ascii_string = s_a;
        start        = 1'b1;
        tick();
        start = 1'b0;
        wait_rises("restart_wait", 11, 400);
        ascii_string = s_b;
        start        = 1'b1;
        tick();
        start = 1'b0;
        wait_done("restart_done_timeout", 600);
        repeat (60) tick();
        chk("restart_done_once", 32'(done_cnt), 32'd1);
        chk("restart_idle", 32'(busy), 32'd0);
        build_exp(s_a, 1'b0, 1'b1);
        compare_seq("restart_seq");

        // Reset during byte 20's strobe
        clear_mon();
        s_a          = rand_string();
        ascii_string = s_a;
        start        = 1'b1;
        tick();
        start = 1'b0;
        wait_rises("midrst_wait", 21, 400);
        chk("midrst_e_before", 32'(lcd_e), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_e_drop", 32'(lcd_e), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd1);
        chk("midrst_data", 32'(lcd_data), 32'h00);
        chk("midrst_rs", 32'(lcd_rs), 32'd0);
        tick();
        clear_mon();
        rst_n   = 1'b1;
        rel_cyc = cyc;
        wait_idle("midrst_idle_timeout", 400);
        chk("midrst_first_rise", 32'(rise_cyc.size() > 0 ? rise_cyc[0] - rel_cyc : -1), PU + 1);
        build_exp('0, 1'b1, 1'b0);
        compare_seq("midrst_init_seq");
        repeat (20) tick();
        chk("midrst_no_string", 32'(seen_q.size()), 32'd4);
        chk("midrst_no_done", 32'(done_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
